pcie_axil_csr_bridge: RTL and testbench
=======================================

Name: pcie_axil_csr_bridge

Overview:
- AXI-lite slave that terminates the 32-bit AXI-lite master port of the PCIe completer (CQ/CC to AXI-lite) stage.
- Converts each AXI-lite access into a single-outstanding register-bus strobe with wait/ack handshake, for the CSR blocks behind a BAR.
- Bounds every access with a timeout, so a dead register target can never stall the PCIe completer.

Parameters:
- AXIL_DATA_WIDTH, 32, AXI-lite and register data width.
- AXIL_ADDR_WIDTH, 64, AXI-lite address width (matches upstream master).
- AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, byte-strobe width.
- REG_ADDR_WIDTH, 16, register-bus address width; upper AXI-lite address bits are dropped.
- TIMEOUT, 16, cycles without ack before forced completion; 0 = never time out.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axil_awaddr  in  AXIL_ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid/s_axil_awready  in/out  1  AW handshake
- s_axil_wdata  in  AXIL_DATA_WIDTH  write data
- s_axil_wstrb  in  AXIL_STRB_WIDTH  byte strobes
- s_axil_wvalid/s_axil_wready  in/out  1  W handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid/s_axil_bready  out/in  1  B handshake
- s_axil_araddr  in  AXIL_ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid/s_axil_arready  in/out  1  AR handshake
- s_axil_rdata  out  AXIL_DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid/s_axil_rready  out/in  1  R handshake
- reg_wr_addr  out  REG_ADDR_WIDTH  word-aligned write address
- reg_wr_data  out  AXIL_DATA_WIDTH  write data
- reg_wr_strb  out  AXIL_STRB_WIDTH  byte strobes
- reg_wr_en  out  1  write strobe, held until ack/timeout
- reg_wr_wait  in  1  target busy; suspends timeout
- reg_wr_ack  in  1  write done
- reg_rd_addr  out  REG_ADDR_WIDTH  word-aligned read address
- reg_rd_en  out  1  read strobe, held until ack/timeout
- reg_rd_data  in  AXIL_DATA_WIDTH  read data, valid with reg_rd_ack
- reg_rd_wait  in  1  target busy; suspends timeout
- reg_rd_ack  in  1  read done

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - all readies, bvalid, rvalid, reg_wr_en and reg_rd_en = 0;
  - bresp, rresp and rdata = 0;
  - reg addr/data/strb = 0;
  - timeout counter = 0;
  - state = IDLE;
  - priority flag = read-first.
- States: IDLE, WR, RD, BRESP, RRESP. Exactly one transaction is outstanding at a time.
- Read and write acceptance in IDLE:
  - A write is eligible only when awvalid and wvalid are both high. awready and wready then assert together for exactly one cycle, combinationally from state and arbitration.
  - A read is eligible when arvalid is high; arready asserts for one cycle.
  - When a write and a read are both eligible, priority alternates: the flag toggles to favour the channel not served last.
- Register addressing: reg address = AXI address[REG_ADDR_WIDTH-1:0] with the low log2(AXIL_STRB_WIDTH) bits forced to 0. Address, data and strb are latched on acceptance.
- Register strobe:
  - Acceptance at cycle N; reg_*_en is high from N+1 until ack or timeout, inclusive of the ack cycle.
  - The ack is sampled only while en is high.
- Timeout counter:
  - Increments each cycle that en is high with ack=0 and wait=0.
  - Cleared while wait=1 and on every new transaction.
  - Timeout fires when count reaches TIMEOUT (TIMEOUT>0).
  - If ack and timeout expiry coincide, ack wins (normal completion, data used).
- Completion:
  - On ack at cycle M: bvalid or rvalid rises at M+1, with resp=OKAY (2'b00) and rdata = the captured reg_rd_data.
  - Minimum latency is acceptance to valid = 2 cycles.
  - On timeout: en drops; valid rises the next cycle with the timeout response (see Optional Feature).
- Response hold: bvalid/rvalid and the response fields stay stable until bready/rready. On that handshake, return to IDLE; a new acceptance is possible in the following cycle.
- Reset mid-operation: the pending transaction is discarded, no response is issued, and all outputs return to reset values the cycle after rst is sampled high.
- awprot/arprot ignored; no exclusive/burst support.

Optional Feature:
- Macro: PCIE_AXIL_CSR_BRIDGE_SLVERR_EN.
- Defined: timeout completes with resp=SLVERR (2'b10), and read data = 0.
- Undefined: timeout completes with resp=OKAY (2'b00), and read data = all-ones (0xFFFFFFFF, PCIe master-abort style).
- Normal completions are identical in both builds.

Decomposition:
- Shared package/header holds:
  - AXI response constants (OKAY=2'b00, SLVERR=2'b10);
  - the state encoding (IDLE, WR, RD, BRESP, RRESP);
  - the timeout read-data constants.
- One natural sub-module: pcie_axil_csr_timeout, a loadable/clearable counter with TIMEOUT parameter, inputs en/ack/wait and output expired. It is used by the read and write paths through the shared FSM.

Test Plan:
- Write test: write addr 0x0000_0000_0000_1236, data 0xA5A5_1234, strb 4'b0011, reg_wr_ack 3 cycles after en rises → reg_wr_addr=0x1234, reg_wr_strb=4'b0011, en high 3 cycles, bvalid 1 cycle after ack with bresp=00.
- Read test: read 0x40, reg_rd_ack on the first en cycle with data 0xDEADBEEF → rvalid 2 cycles after arready, rdata=0xDEADBEEF, rresp=00; hold rready low 5 cycles → rvalid/rdata stable.
- Simultaneous test: aw+w and ar valid in the same cycle, repeated 4 times → served order alternates R,W,R,W; never two en high at once.
- Timeout test: TIMEOUT=16, no ack; then repeat with wait high for 10 cycles first → completion after 16 en cycles (26 with wait); resp/data per macro (SLVERR+0 or OKAY+0xFFFFFFFF).
- Boundary tests:
  - ack on the exact expiry cycle → OKAY with ack data.
  - rst pulsed while reg_rd_en is high → en, rvalid and readies 0 the next cycle, no spurious rvalid afterwards, next read completes normally.

Source files
------------

// File: rtl/pcie_axil_csr_bridge_pkg.sv
// Shared definitions for the PCIe AXI-lite CSR bridge.
// Holds the AXI response codes, the bridge state encoding and the fill bit
// used to build the read data returned on a timed-out read.
package pcie_axil_csr_bridge_pkg;

   localparam int unsigned RESP_W  = 2;
   localparam int unsigned STATE_W = 3;

   // AXI response codes used by the bridge
   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   // Bridge state: one transaction outstanding at a time
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_RD    = 3'd2,
      ST_BRESP = 3'd3,
      ST_RRESP = 3'd4
   } state_t;

   // Timed-out read data is a replication of one of these bits:
   // all-ones mimics a PCIe master abort, zero pairs with SLVERR.
   localparam logic TO_FILL_ABORT  = 1'b1;
   localparam logic TO_FILL_SLVERR = 1'b0;

endpackage

// File: rtl/pcie_axil_csr_timeout.sv
// Access timeout counter for the CSR bridge.
// Counts cycles in which the register strobe is up with neither ack nor wait;
// wait clears the count, clr restarts it for a new transaction. expired is
// a combinational flag raised in the last strobe cycle before the strobe is
// withdrawn, and never when ack is present in that same cycle.
// Ports: clk, rst (sync, active-high), clr, en, ack, stall (target wait), expired.
// TIMEOUT = 0 disables expiry entirely.
module pcie_axil_csr_timeout
   import pcie_axil_csr_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic ack,
   input  logic stall,
   output logic expired
);

   if (TIMEOUT > 0) begin : g_count
      localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] count;

      // Idle cycles of an active strobe; a busy target restarts the window
      always_ff @(posedge clk) begin
         if (rst || clr) begin
            count <= '0;
         end else if (en && stall) begin
            count <= '0;
         end else if (en && !ack) begin
            count <= count + CNT_W'(1);
         end
      end

      // Fires in the strobe cycle that would be the TIMEOUT-th idle one
      assign expired = en && !ack && !stall && (count == CNT_W'(TIMEOUT - 1));
   end else begin : g_never
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en, ack, stall};
      assign expired       = 1'b0;
   end

endmodule

// File: rtl/pcie_axil_csr_bridge.sv
// AXI-lite slave to register-bus bridge for CSR blocks behind a PCIe BAR.
// Each AXI-lite access becomes one register strobe (reg_wr_en / reg_rd_en)
// held until ack or timeout; completion is returned on B or R and held until
// the master takes it. Reads and writes alternate priority when both arrive.
// Ports: clk, rst (sync, active-high); AXI-lite AW/W/B/AR/R slave channels
// (awprot/arprot ignored); register bus write (addr/data/strb/en/wait/ack)
// and read (addr/en/data/wait/ack).
// Build option: define PCIE_AXIL_CSR_BRIDGE_SLVERR_EN to complete timeouts
// with SLVERR and zero read data; otherwise timeouts complete OKAY with
// all-ones read data.
module pcie_axil_csr_bridge
   import pcie_axil_csr_bridge_pkg::*;
#(
   parameter int unsigned AXIL_DATA_WIDTH = 32,
   parameter int unsigned AXIL_ADDR_WIDTH = 64,
   parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
   parameter int unsigned REG_ADDR_WIDTH  = 16,
   parameter int unsigned TIMEOUT         = 16
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]                 s_axil_awprot,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]                 s_axil_arprot,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,

   output logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr,
   output logic [AXIL_DATA_WIDTH-1:0] reg_wr_data,
   output logic [AXIL_STRB_WIDTH-1:0] reg_wr_strb,
   output logic                       reg_wr_en,
   input  logic                       reg_wr_wait,
   input  logic                       reg_wr_ack,
   output logic [REG_ADDR_WIDTH-1:0]  reg_rd_addr,
   output logic                       reg_rd_en,
   input  logic [AXIL_DATA_WIDTH-1:0] reg_rd_data,
   input  logic                       reg_rd_wait,
   input  logic                       reg_rd_ack
);

   // Clears the byte-offset bits so the register bus only sees word addresses
   localparam logic [REG_ADDR_WIDTH-1:0] WORD_MASK = ~REG_ADDR_WIDTH'(AXIL_STRB_WIDTH - 1);

`ifdef PCIE_AXIL_CSR_BRIDGE_SLVERR_EN
   localparam logic [RESP_W-1:0] TO_RESP = RESP_SLVERR;
   localparam logic              TO_FILL = TO_FILL_SLVERR;
`else
   localparam logic [RESP_W-1:0] TO_RESP = RESP_OKAY;
   localparam logic              TO_FILL = TO_FILL_ABORT;
`endif

   state_t state;
   logic   rd_first;      // 1: read wins a tie, 0: write wins a tie

   logic wr_elig;
   logic rd_elig;
   logic grant_wr;
   logic grant_rd;
   logic to_ack;
   logic to_stall;
   logic to_expired;

   // Arbitration in IDLE; readies are combinational so acceptance costs no cycle
   assign wr_elig  = s_axil_awvalid && s_axil_wvalid;
   assign rd_elig  = s_axil_arvalid;
   assign grant_wr = !rst && (state == ST_IDLE) && wr_elig && (!rd_elig || !rd_first);
   assign grant_rd = !rst && (state == ST_IDLE) && rd_elig && (!wr_elig ||  rd_first);

   assign s_axil_awready = grant_wr;
   assign s_axil_wready  = grant_wr;
   assign s_axil_arready = grant_rd;

   // Only one strobe is ever up, so one counter serves both paths
   assign to_ack   = (reg_wr_en && reg_wr_ack)  || (reg_rd_en && reg_rd_ack);
   assign to_stall = (reg_wr_en && reg_wr_wait) || (reg_rd_en && reg_rd_wait);

   pcie_axil_csr_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (grant_wr || grant_rd),
      .en      (reg_wr_en || reg_rd_en),
      .ack     (to_ack),
      .stall   (to_stall),
      .expired (to_expired)
   );

   // Transaction sequencer with registered register-bus and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         rd_first      <= 1'b1;
         reg_wr_addr   <= '0;
         reg_wr_data   <= '0;
         reg_wr_strb   <= '0;
         reg_wr_en     <= 1'b0;
         reg_rd_addr   <= '0;
         reg_rd_en     <= 1'b0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rresp  <= RESP_OKAY;
         s_axil_rdata  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (grant_wr) begin
                  reg_wr_addr <= s_axil_awaddr[REG_ADDR_WIDTH-1:0] & WORD_MASK;
                  reg_wr_data <= s_axil_wdata;
                  reg_wr_strb <= s_axil_wstrb;
                  reg_wr_en   <= 1'b1;
                  rd_first    <= 1'b1;
                  state       <= ST_WR;
               end else if (grant_rd) begin
                  reg_rd_addr <= s_axil_araddr[REG_ADDR_WIDTH-1:0] & WORD_MASK;
                  reg_rd_en   <= 1'b1;
                  rd_first    <= 1'b0;
                  state       <= ST_RD;
               end
            end

            // Ack is checked first so it wins over a coincident expiry
            ST_WR: begin
               if (reg_wr_ack) begin
                  reg_wr_en     <= 1'b0;
                  s_axil_bvalid <= 1'b1;
                  s_axil_bresp  <= RESP_OKAY;
                  state         <= ST_BRESP;
               end else if (to_expired) begin
                  reg_wr_en     <= 1'b0;
                  s_axil_bvalid <= 1'b1;
                  s_axil_bresp  <= TO_RESP;
                  state         <= ST_BRESP;
               end
            end

            ST_RD: begin
               if (reg_rd_ack) begin
                  reg_rd_en     <= 1'b0;
                  s_axil_rvalid <= 1'b1;
                  s_axil_rresp  <= RESP_OKAY;
                  s_axil_rdata  <= reg_rd_data;
                  state         <= ST_RRESP;
               end else if (to_expired) begin
                  reg_rd_en     <= 1'b0;
                  s_axil_rvalid <= 1'b1;
                  s_axil_rresp  <= TO_RESP;
                  s_axil_rdata  <= {AXIL_DATA_WIDTH{TO_FILL}};
                  state         <= ST_RRESP;
               end
            end

            ST_BRESP: begin
               if (s_axil_bready) begin
                  s_axil_bvalid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end

            ST_RRESP: begin
               if (s_axil_rready) begin
                  s_axil_rvalid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Protection and dropped upper address bits are intentionally unused
   logic unused_bits;
   assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                          s_axil_awaddr[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH],
                          s_axil_araddr[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH]};

endmodule

// File: tb/tb_pcie_axil_csr_bridge.sv
// Self-checking bench for pcie_axil_csr_bridge.
// A behavioural register target answers the strobes; an independent word
// array tracks what the registers must contain, and access timing and
// completion codes are predicted from the acceptance/ack/timeout rules.
module tb_pcie_axil_csr_bridge;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 64;
   localparam int unsigned SW  = 4;
   localparam int unsigned RAW = 16;
   localparam int          TMO = 16;

`ifdef PCIE_AXIL_CSR_BRIDGE_SLVERR_EN
   localparam logic [1:0]  TO_RESP = 2'b10;
   localparam logic [31:0] TO_DATA = 32'h0000_0000;
`else
   localparam logic [1:0]  TO_RESP = 2'b00;
   localparam logic [31:0] TO_DATA = 32'hFFFF_FFFF;
`endif

   logic          clk;
   logic          rst;
   logic [AW-1:0] s_axil_awaddr;
   logic [2:0]    s_axil_awprot;
   logic          s_axil_awvalid;
   logic          s_axil_awready;
   logic [DW-1:0] s_axil_wdata;
   logic [SW-1:0] s_axil_wstrb;
   logic          s_axil_wvalid;
   logic          s_axil_wready;
   logic [1:0]    s_axil_bresp;
   logic          s_axil_bvalid;
   logic          s_axil_bready;
   logic [AW-1:0] s_axil_araddr;
   logic [2:0]    s_axil_arprot;
   logic          s_axil_arvalid;
   logic          s_axil_arready;
   logic [DW-1:0] s_axil_rdata;
   logic [1:0]    s_axil_rresp;
   logic          s_axil_rvalid;
   logic          s_axil_rready;
   logic [RAW-1:0] reg_wr_addr;
   logic [DW-1:0] reg_wr_data;
   logic [SW-1:0] reg_wr_strb;
   logic          reg_wr_en;
   logic          reg_wr_wait;
   logic          reg_wr_ack;
   logic [RAW-1:0] reg_rd_addr;
   logic          reg_rd_en;
   logic [DW-1:0] reg_rd_data;
   logic          reg_rd_wait;
   logic          reg_rd_ack;

   pcie_axil_csr_bridge #(
      .AXIL_DATA_WIDTH (DW),
      .AXIL_ADDR_WIDTH (AW),
      .AXIL_STRB_WIDTH (SW),
      .REG_ADDR_WIDTH  (RAW),
      .TIMEOUT         (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awprot  (s_axil_awprot),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arprot  (s_axil_arprot),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .reg_wr_strb    (reg_wr_strb),
      .reg_wr_en      (reg_wr_en),
      .reg_wr_wait    (reg_wr_wait),
      .reg_wr_ack     (reg_wr_ack),
      .reg_rd_addr    (reg_rd_addr),
      .reg_rd_en      (reg_rd_en),
      .reg_rd_data    (reg_rd_data),
      .reg_rd_wait    (reg_rd_wait),
      .reg_rd_ack     (reg_rd_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] tgt_mem [64];   // contents of the register target
   logic [31:0] exp_mem [64];   // contents the registers must hold

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Strobe cycles expected: ack cycle if it arrives in time, else wait + TIMEOUT
   function automatic int exp_en(input int ack_at, input int stall_n);
      if (ack_at != 0 && ack_at <= stall_n + TMO) return ack_at;
      return stall_n + TMO;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_axil_awaddr = '0; s_axil_awprot = 3'($urandom()); s_axil_awvalid = 1'b0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arprot = 3'($urandom()); s_axil_arvalid = 1'b0;
      s_axil_rready = 1'b0; reg_wr_wait = 1'b0; reg_wr_ack = 1'b0;
      reg_rd_data = $urandom(); reg_rd_wait = 1'b0; reg_rd_ack = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      idle_inputs();
      repeat (n) tick();
      rst = 1'b0;
   endtask

   // Present request(s) and wait (bounded) for acceptance
   task automatic accept(input bit do_wr, input bit do_rd, input logic [63:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [63:0] ra,
                         output bit got_wr, output bit got_rd, output bit both_rdy);
      s_axil_awaddr = wa; s_axil_wdata = wd; s_axil_wstrb = ws;
      s_axil_awvalid = do_wr; s_axil_wvalid = do_wr;
      s_axil_araddr = ra; s_axil_arvalid = do_rd;
      got_wr = 1'b0; got_rd = 1'b0; both_rdy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (s_axil_awready || s_axil_wready || s_axil_arready) begin
            got_wr   = s_axil_awready && s_axil_wready;
            got_rd   = s_axil_arready;
            both_rdy = s_axil_arready && (s_axil_awready || s_axil_wready);
            break;
         end
         tick();
      end
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
   endtask

   // Act as the register target until the AXI completion appears (bounded)
   task automatic serve(input bit is_wr, input int ack_at, input int stall_n,
                        output int en_cycles, output int lat, output bit got_valid,
                        output bit overlap, output logic [15:0] addr_seen,
                        output logic [31:0] wd_seen, output logic [3:0] ws_seen);
      bit st, ak;
      en_cycles = 0; lat = 1; got_valid = 1'b0; overlap = 1'b0;
      addr_seen = '0; wd_seen = '0; ws_seen = '0;
      for (int i = 0; i < 200; i++) begin
         if (is_wr ? s_axil_bvalid : s_axil_rvalid) begin
            got_valid = 1'b1;
            break;
         end
         if (reg_wr_en && reg_rd_en) overlap = 1'b1;
         if (is_wr ? reg_wr_en : reg_rd_en) begin
            en_cycles++;
            if (en_cycles == 1) begin
               addr_seen = is_wr ? reg_wr_addr : reg_rd_addr;
               wd_seen   = reg_wr_data;
               ws_seen   = reg_wr_strb;
            end
            st = (en_cycles <= stall_n);
            ak = (ack_at != 0) && (en_cycles == ack_at);
            if (is_wr) begin
               reg_wr_wait = st; reg_wr_ack = ak;
               if (ak) tgt_mem[reg_wr_addr[7:2]] = merge(tgt_mem[reg_wr_addr[7:2]], reg_wr_data, reg_wr_strb);
            end else begin
               reg_rd_wait = st; reg_rd_ack = ak;
               reg_rd_data = ak ? tgt_mem[reg_rd_addr[7:2]] : $urandom();
            end
         end
         tick();
         reg_wr_ack = 1'b0; reg_wr_wait = 1'b0;
         reg_rd_ack = 1'b0; reg_rd_wait = 1'b0; reg_rd_data = $urandom();
         lat++;
      end
   endtask

   // Capture the completion, stall the master for hold cycles, then take it
   task automatic finish_resp(input bit is_wr, input int hold, output logic [1:0] resp,
                              output logic [31:0] data, output bit stable, output bit dropped);
      resp = is_wr ? s_axil_bresp : s_axil_rresp;
      data = is_wr ? 32'h0 : s_axil_rdata;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if ((is_wr ? s_axil_bvalid : s_axil_rvalid) !== 1'b1) stable = 1'b0;
         if ((is_wr ? s_axil_bresp : s_axil_rresp) !== resp) stable = 1'b0;
         if (!is_wr && s_axil_rdata !== data) stable = 1'b0;
      end
      if (is_wr) s_axil_bready = 1'b1; else s_axil_rready = 1'b1;
      tick();
      s_axil_bready = 1'b0; s_axil_rready = 1'b0;
      dropped = !(is_wr ? s_axil_bvalid : s_axil_rvalid);
   endtask

   task automatic test_reset();
      apply_reset(3);
      n_cmp++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin
         n_fail++; $display("FAIL reset_readies: got %b expected 000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
      n_cmp++; if ({s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_valids_en: got %b expected 0000", {s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en}); end
      n_cmp++; if ({s_axil_bresp, s_axil_rresp, s_axil_rdata} !== 36'h0) begin
         n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", {s_axil_bresp, s_axil_rresp, s_axil_rdata}); end
      n_cmp++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr} !== 68'h0) begin
         n_fail++; $display("FAIL reset_regbus: got %h expected 0", {reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr}); end
   endtask

   task automatic test_write();
      bit gw, gr, br, gv, ov, stb, drp; int en, lat; logic [15:0] a; logic [31:0] wd, d; logic [3:0] ws; logic [1:0] rs;
      accept(1'b1, 1'b0, 64'h0000_0000_0000_1236, 32'hA5A5_1234, 4'b0011, 64'h0, gw, gr, br);
      n_cmp++; if (gw !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b expected 1", gw); end
      serve(1'b1, 3, 0, en, lat, gv, ov, a, wd, ws);
      n_cmp++; if (a !== 16'h1234) begin n_fail++; $display("FAIL wr_addr: got %h expected 1234", a); end
      n_cmp++; if (ws !== 4'b0011 || wd !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL wr_data_strb: got %h/%b expected a5a51234/0011", wd, ws); end
      n_cmp++; if (en !== 3) begin n_fail++; $display("FAIL wr_en_cycles: got %0d expected 3", en); end
      n_cmp++; if (gv !== 1'b1 || lat !== 4) begin
         n_fail++; $display("FAIL wr_bvalid_latency: got valid=%b lat=%0d expected 1/4", gv, lat); end
      finish_resp(1'b1, 0, rs, d, stb, drp);
      n_cmp++; if (rs !== 2'b00 || drp !== 1'b1) begin
         n_fail++; $display("FAIL wr_bresp: got %b dropped=%b expected 00/1", rs, drp); end
      exp_mem[13] = merge(exp_mem[13], 32'hA5A5_1234, 4'b0011);
   endtask

   task automatic test_read();
      bit gw, gr, br, gv, ov, stb, drp; int en, lat; logic [15:0] a; logic [31:0] wd, d; logic [3:0] ws; logic [1:0] rs;
      tgt_mem[16] = 32'hDEAD_BEEF; exp_mem[16] = 32'hDEAD_BEEF;
      accept(1'b0, 1'b1, 64'h0, 32'h0, 4'h0, 64'h40, gw, gr, br);
      n_cmp++; if (gr !== 1'b1) begin n_fail++; $display("FAIL rd_accept: got %b expected 1", gr); end
      serve(1'b0, 1, 0, en, lat, gv, ov, a, wd, ws);
      n_cmp++; if (a !== 16'h0040) begin n_fail++; $display("FAIL rd_addr: got %h expected 0040", a); end
      n_cmp++; if (gv !== 1'b1 || lat !== 2 || en !== 1) begin
         n_fail++; $display("FAIL rd_latency: got valid=%b lat=%0d en=%0d expected 1/2/1", gv, lat, en); end
      finish_resp(1'b0, 5, rs, d, stb, drp);
      n_cmp++; if (d !== 32'hDEAD_BEEF || rs !== 2'b00) begin
         n_fail++; $display("FAIL rd_data: got %h/%b expected deadbeef/00", d, rs); end
      n_cmp++; if (stb !== 1'b1 || drp !== 1'b1) begin
         n_fail++; $display("FAIL rd_hold: got stable=%b dropped=%b expected 1/1", stb, drp); end
   endtask

   // One access with a given target behaviour, checked against the model
   task automatic run_access(input string tag, input bit is_wr, input logic [63:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input int ack_at, input int stall_n, input int hold);
      bit gw, gr, br, gv, ov, stb, drp, hit; int en, lat, idx; logic [15:0] a; logic [31:0] wd, d, xd;
      logic [3:0] ws; logic [1:0] rs, xr;
      idx = int'(addr[7:2]);
      hit = (ack_at != 0) && (ack_at <= stall_n + TMO);
      xr  = hit ? 2'b00 : TO_RESP;
      xd  = hit ? exp_mem[idx] : TO_DATA;
      accept(is_wr, !is_wr, addr, data, strb, addr, gw, gr, br);
      n_cmp++; if ((is_wr ? gw : gr) !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b expected 1", tag, is_wr ? gw : gr); end
      serve(is_wr, ack_at, stall_n, en, lat, gv, ov, a, wd, ws);
      n_cmp++; if (a !== (addr[15:0] & 16'hFFFC)) begin
         n_fail++; $display("FAIL %s_addr: got %h expected %h", tag, a, addr[15:0] & 16'hFFFC); end
      n_cmp++; if (en !== exp_en(ack_at, stall_n) || gv !== 1'b1 || lat !== en + 1) begin
         n_fail++; $display("FAIL %s_timing: got en=%0d valid=%b lat=%0d expected en=%0d valid=1 lat=%0d",
                            tag, en, gv, lat, exp_en(ack_at, stall_n), exp_en(ack_at, stall_n) + 1); end
      finish_resp(is_wr, hold, rs, d, stb, drp);
      n_cmp++; if (rs !== xr || stb !== 1'b1 || drp !== 1'b1) begin
         n_fail++; $display("FAIL %s_resp: got %b stable=%b dropped=%b expected %b/1/1", tag, rs, stb, drp, xr); end
      if (is_wr) begin
         n_cmp++; if (wd !== data || ws !== strb) begin
            n_fail++; $display("FAIL %s_wdata: got %h/%b expected %h/%b", tag, wd, ws, data, strb); end
         if (hit) exp_mem[idx] = merge(exp_mem[idx], data, strb);
      end else begin
         n_cmp++; if (d !== xd) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", tag, d, xd); end
      end
   endtask

   task automatic test_timeout();
      run_access("to_wr",      1'b1, 64'h1208, 32'h1111_2222, 4'hF, 0, 0, 0);
      run_access("to_rd",      1'b0, 64'h1208, 32'h0, 4'h0, 0, 0, 1);
      run_access("to_rd_wait", 1'b0, 64'h120C, 32'h0, 4'h0, 0, 10, 0);
      run_access("to_wr_wait", 1'b1, 64'h120C, 32'h3333_4444, 4'hF, 0, 10, 0);
   endtask

   task automatic test_ack_at_expiry();
      run_access("exp_ack_wr", 1'b1, 64'h1210, 32'hCAFE_F00D, 4'hF, TMO, 0, 0);
      run_access("exp_ack_rd", 1'b0, 64'h1210, 32'h0, 4'h0, TMO, 0, 2);
   endtask

   task automatic test_simultaneous();
      bit gw, gr, br, gv, ov, stb, drp, rd_turn, is_wr; int en, lat;
      logic [15:0] a; logic [31:0] wd, d, dat; logic [3:0] ws; logic [1:0] rs;
      apply_reset(2);
      rd_turn = 1'b1;
      for (int r = 0; r < 4; r++) begin
         dat = $urandom();
         accept(1'b1, 1'b1, 64'h1220, dat, 4'hF, 64'h1224, gw, gr, br);
         n_cmp++; if (gr !== rd_turn || gw !== !rd_turn || br !== 1'b0) begin
            n_fail++; $display("FAIL sim_order round %0d: got rd=%b wr=%b both=%b expected rd=%b", r, gr, gw, br, rd_turn); end
         is_wr = !rd_turn;
         serve(is_wr, 2, 0, en, lat, gv, ov, a, wd, ws);
         n_cmp++; if (ov !== 1'b0 || gv !== 1'b1) begin
            n_fail++; $display("FAIL sim_overlap round %0d: got overlap=%b valid=%b expected 0/1", r, ov, gv); end
         finish_resp(is_wr, 0, rs, d, stb, drp);
         if (is_wr) exp_mem[8] = merge(exp_mem[8], dat, 4'hF);
         else begin
            n_cmp++; if (d !== exp_mem[9] || rs !== 2'b00) begin
               n_fail++; $display("FAIL sim_rdata round %0d: got %h/%b expected %h/00", r, d, rs, exp_mem[9]); end
         end
         rd_turn = !rd_turn;
      end
   endtask

   task automatic test_reset_mid_read();
      bit gw, gr, br, spur;
      accept(1'b0, 1'b1, 64'h0, 32'h0, 4'h0, 64'h1230, gw, gr, br);
      n_cmp++; if (reg_rd_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_en_up: got %b expected 1", reg_rd_en); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({reg_rd_en, s_axil_rvalid, s_axil_arready, s_axil_awready, s_axil_wready} !== 5'b0) begin
         n_fail++; $display("FAIL rstmid_clear: got %b expected 00000",
                            {reg_rd_en, s_axil_rvalid, s_axil_arready, s_axil_awready, s_axil_wready}); end
      spur = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_axil_rvalid || s_axil_bvalid || reg_rd_en || reg_wr_en) spur = 1'b1;
      end
      n_cmp++; if (spur !== 1'b0) begin n_fail++; $display("FAIL rstmid_spurious: got %b expected 0", spur); end
      run_access("rstmid_next", 1'b0, 64'h1230, 32'h0, 4'h0, 2, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] a; bit w; int ak;
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom());
         a = {32'($urandom()), 16'($urandom()), 16'h1200 | 16'($urandom_range(0, 255))};
         ak = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         run_access(w ? "rnd_wr" : "rnd_rd", w, a, $urandom(), 4'($urandom()), ak,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         tgt_mem[i] = $urandom();
         exp_mem[i] = tgt_mem[i];
      end
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_ack_at_expiry();
      test_simultaneous();
      test_reset_mid_read();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
